// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: per-frame collision/goal checks, game FSM, lives and level.
// Optional FROGGER_GOD_MODE_EN disables car collisions (goal/level behaviour unchanged).

module frogger_car_hit #(
  parameter int GRID = 32
) (
  input  logic [9:0] frog_x,
  input  logic [9:0] frog_y,
  input  logic [9:0] car_x,
  input  logic [3:0] car_row,
  output logic       hit
);
  logic [10:0] row_y, fx, fy, cx, g;

  // 11-bit sums so a car near the right edge does not wrap past 1023
  assign g     = 11'(GRID);
  assign row_y = 11'(car_row) * g;
  assign fx    = {1'b0, frog_x};
  assign fy    = {1'b0, frog_y};
  assign cx    = {1'b0, car_x};
  assign hit   = (fy == row_y) && (fx < cx + g) && (cx < fx + g);
endmodule

module frogger_game_ctrl #(
  parameter int GRID           = 32,
  parameter int NUM_CARS       = 2,
  parameter int START_LIVES    = 3,
  parameter int MAX_LEVEL      = 9,
  parameter int HIT_FRAMES     = 60,
  parameter int LEVELUP_FRAMES = 30
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_Frame_Tick,
  input  logic                    i_Start,
  input  logic [9:0]              i_Frog_X,
  input  logic [9:0]              i_Frog_Y,
  input  logic [10*NUM_CARS-1:0]  i_Car_X,
  input  logic [4*NUM_CARS-1:0]   i_Car_Row,
  output logic [2:0]              o_State,
  output logic [3:0]              o_Level,
  output logic [2:0]              o_Lives,
  output logic                    o_Frog_Reset,
  output logic                    o_Cars_Run,
  output logic                    o_Flash,
  output logic                    o_Win
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PLAY = 3'd1, S_HIT = 3'd2, S_LEVEL_UP = 3'd3, S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [3:0] MAX_LVL  = 4'(MAX_LEVEL);
  localparam logic [2:0] LIVES0   = 3'(START_LIVES);
  localparam logic [7:0] HIT_LAST = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] LVL_LAST = 8'(LEVELUP_FRAMES - 1);

  state_t              state;
  logic                start_q, press, hit, goal;
  logic [7:0]          frame_cnt, cnt_nxt;
  logic [NUM_CARS-1:0] lane_hit;

  for (genvar g = 0; g < NUM_CARS; g++) begin : g_lane
    frogger_car_hit #(.GRID(GRID)) u_hit (
      .frog_x (i_Frog_X),
      .frog_y (i_Frog_Y),
      .car_x  (i_Car_X[10*g +: 10]),
      .car_row(i_Car_Row[4*g +: 4]),
      .hit    (lane_hit[g])
    );
  end

`ifdef FROGGER_GOD_MODE_EN
  assign hit = 1'b0;
`else
  assign hit = |lane_hit;
`endif

  assign goal    = (i_Frog_Y == 10'd0);
  assign press   = i_Start & ~start_q;
  assign cnt_nxt = frame_cnt + 8'd1;
  assign o_State = state;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      frame_cnt    <= 8'd0;
      o_Level      <= 4'd1;
      o_Lives      <= LIVES0;
      o_Frog_Reset <= 1'b0;
      o_Cars_Run   <= 1'b0;
      o_Flash      <= 1'b0;
      o_Win        <= 1'b0;
    end else begin
      start_q      <= i_Start;
      o_Frog_Reset <= 1'b0;
      // every state entry below overrides this with a clear
      if (i_Frame_Tick) frame_cnt <= cnt_nxt;
      case (state)
        S_IDLE: if (press) begin
          o_Level      <= 4'd1;
          o_Lives      <= LIVES0;
          o_Win        <= 1'b0;
          o_Frog_Reset <= 1'b1;
          o_Cars_Run   <= 1'b1;
          frame_cnt    <= 8'd0;
          state        <= S_PLAY;
        end
        S_PLAY: if (i_Frame_Tick) begin
          if (hit) begin
            o_Lives    <= (o_Lives != 3'd0) ? o_Lives - 3'd1 : 3'd0;
            o_Cars_Run <= 1'b0;
            frame_cnt  <= 8'd0;
            state      <= S_HIT;
          end else if (goal) begin
            o_Cars_Run <= 1'b0;
            frame_cnt  <= 8'd0;
            if (o_Level < MAX_LVL) begin
              state <= S_LEVEL_UP;
            end else begin
              o_Win <= 1'b1;
              state <= S_GAME_OVER;
            end
          end
        end
        S_HIT: if (i_Frame_Tick) begin
          if (frame_cnt == HIT_LAST) begin
            frame_cnt <= 8'd0;
            o_Flash   <= 1'b0;
            if (o_Lives == 3'd0) begin
              state <= S_GAME_OVER;
            end else begin
              o_Frog_Reset <= 1'b1;
              o_Cars_Run   <= 1'b1;
              state        <= S_PLAY;
            end
          end else begin
            o_Flash <= cnt_nxt[3];
          end
        end
        S_LEVEL_UP: if (i_Frame_Tick && frame_cnt == LVL_LAST) begin
          o_Level      <= (o_Level < MAX_LVL) ? o_Level + 4'd1 : o_Level;
          o_Frog_Reset <= 1'b1;
          o_Cars_Run   <= 1'b1;
          frame_cnt    <= 8'd0;
          state        <= S_PLAY;
        end
        S_GAME_OVER: if (press) begin
          frame_cnt <= 8'd0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frogger_game_ctrl.sv
module tb_frogger_game_ctrl;
  localparam logic [2:0] IDLE = 3'd0, PLAY = 3'd1, HIT = 3'd2, LVUP = 3'd3, GOVR = 3'd4;

  logic        clk = 1'b0;
  logic        rst, tick, start;
  logic [9:0]  frog_x, frog_y;
  logic [19:0] car_x;
  logic [7:0]  car_row;
  logic [2:0]  st, lives;
  logic [3:0]  level;
  logic        frog_rst, cars_run, flash, win;

  frogger_game_ctrl dut (
    .i_Clk(clk), .i_Reset(rst), .i_Frame_Tick(tick), .i_Start(start),
    .i_Frog_X(frog_x), .i_Frog_Y(frog_y), .i_Car_X(car_x), .i_Car_Row(car_row),
    .o_State(st), .o_Level(level), .o_Lives(lives), .o_Frog_Reset(frog_rst),
    .o_Cars_Run(cars_run), .o_Flash(flash), .o_Win(win)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       tag;
    logic [13:0] v;
  } exp_t;

  exp_t  q[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  string cur_tag = "reset";

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [13:0] act;
    exp_t e;
    act = {st, level, lives, frog_rst, cars_run, flash, win};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL %s: check for cycle %0d missed (now %0d)", e.tag, e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s cyc=%0d: got st=%0d lv=%0d li=%0d fr=%b run=%b fl=%b win=%b, want st=%0d lv=%0d li=%0d fr=%b run=%b fl=%b win=%b",
                 e.tag, cyc, act[13:11], act[10:7], act[6:4], act[3], act[2], act[1], act[0],
                 e.v[13:11], e.v[10:7], e.v[6:4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic expect_at(int c, logic [2:0] s, logic [3:0] lv, logic [2:0] li,
                           logic fr, logic run, logic fl, logic w);
    exp_t e;
    e.cyc = c; e.tag = cur_tag; e.v = {s, lv, li, fr, run, fl, w};
    q.push_back(e);
    if (fr) begin
      e.cyc = c + 1; e.v = {s, lv, li, 1'b0, run, fl, w};
      q.push_back(e);
    end
  endtask

  task automatic tick_exp(logic [2:0] s, logic [3:0] lv, logic [2:0] li,
                          logic fr, logic run, logic fl, logic w);
    tick = 1'b1;
    expect_at(cyc + 1, s, lv, li, fr, run, fl, w);
    step(); tick = 1'b0; step();
  endtask

  task automatic press_exp(logic [2:0] s, logic [3:0] lv, logic [2:0] li,
                           logic fr, logic run, logic fl, logic w);
    start = 1'b1;
    expect_at(cyc + 1, s, lv, li, fr, run, fl, w);
    step(); start = 1'b0; step();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
    end
  endtask

  task automatic set_scene(logic [9:0] fx, logic [9:0] fy, logic [9:0] c0x, logic [3:0] c0r,
                           logic [9:0] c1x, logic [3:0] c1r);
    frog_x = fx; frog_y = fy;
    car_x = {c1x, c0x}; car_row = {c1r, c0r};
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0;
    set_scene(10'd64, 10'd320, 10'd500, 4'd10, 10'd0, 4'd15);
    step(); step();
    expect_at(cyc + 1, IDLE, 4'd1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); rst = 1'b0; step();

    cur_tag = "start";
    press_exp(PLAY, 4'd1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (st !== PLAY) begin n_bad++; $display("FAIL start_direct: st=%0d", st); end
    n_cmp++;
    if (cars_run !== 1'b1) begin n_bad++; $display("FAIL start_direct: run=%b", cars_run); end
    n_cmp++;
    if (lives !== 3'd3) begin n_bad++; $display("FAIL start_direct: lives=%0d", lives); end

    cur_tag = "no_hit_right_adjacent";
    set_scene(10'd64, 10'd320, 10'd96, 4'd10, 10'd0, 4'd15);
    tick_exp(PLAY, 4'd1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    cur_tag = "no_hit_left_adjacent";
    set_scene(10'd64, 10'd320, 10'd32, 4'd10, 10'd0, 4'd15);
    tick_exp(PLAY, 4'd1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    cur_tag = "no_hit_other_row";
    set_scene(10'd64, 10'd320, 10'd64, 4'd9, 10'd0, 4'd15);
    tick_exp(PLAY, 4'd1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);

    cur_tag = "hit_car0";
    set_scene(10'd64, 10'd320, 10'd80, 4'd10, 10'd0, 4'd15);
    tick_exp(HIT, 4'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (lives !== 3'd2) begin n_bad++; $display("FAIL hit_direct: lives=%0d", lives); end
    ticks(7);
    cur_tag = "hit_flash_on";
    tick_exp(HIT, 4'd1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(51);
    cur_tag = "hit_recover";
    tick_exp(PLAY, 4'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);

    set_scene(10'd64, 10'd0, 10'd80, 4'd10, 10'd0, 4'd15);
    for (int l = 1; l < 9; l++) begin
      cur_tag = $sformatf("goal_lv%0d", l);
      tick_exp(LVUP, 4'(l), 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      ticks(29);
      cur_tag = $sformatf("levelup_to%0d", l + 1);
      tick_exp(PLAY, 4'(l + 1), 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    cur_tag = "goal_max_win";
    tick_exp(GOVR, 4'd9, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (win !== 1'b1) begin n_bad++; $display("FAIL win_direct: win=%b", win); end
    cur_tag = "gameover_ignores_hit";
    set_scene(10'd64, 10'd320, 10'd80, 4'd10, 10'd0, 4'd15);
    tick_exp(GOVR, 4'd9, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    cur_tag = "gameover_to_idle";
    press_exp(IDLE, 4'd9, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);

    cur_tag = "restart";
    press_exp(PLAY, 4'd1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    cur_tag = "hit_car1";
    set_scene(10'd64, 10'd320, 10'd500, 4'd2, 10'd50, 4'd10);
    tick_exp(HIT, 4'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(59);
    tick_exp(PLAY, 4'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    cur_tag = "hit_no_wrap_1023";
    set_scene(10'd1000, 10'd320, 10'd1010, 4'd10, 10'd0, 4'd15);
    tick_exp(HIT, 4'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(59);
    tick_exp(PLAY, 4'd1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    cur_tag = "last_life";
    tick_exp(HIT, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(59);
    cur_tag = "lose";
    tick_exp(GOVR, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (win !== 1'b0) begin n_bad++; $display("FAIL lose_direct: win=%b", win); end
    cur_tag = "lose_to_idle";
    press_exp(IDLE, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    cur_tag = "restart2";
    press_exp(PLAY, 4'd1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    cur_tag = "hit_beats_goal";
    set_scene(10'd64, 10'd0, 10'd64, 4'd0, 10'd0, 4'd15);
    tick_exp(HIT, 4'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(3);
    cur_tag = "reset_mid_hit";
    rst = 1'b1; tick = 1'b1;
    expect_at(cyc + 1, IDLE, 4'd1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); rst = 1'b0; tick = 1'b0;
    n_cmp++;
    if (st !== IDLE) begin n_bad++; $display("FAIL reset_direct: st=%0d", st); end
    repeat (4) step();

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL %s: check for cycle %0d never reached", e.tag, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
